// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizing for the reorder buffer.
// Supplies the default ROB_SIZE (overridable through the ROB_SIZE define) and the per-entry control struct.
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEF = `ROB_SIZE;
  localparam int TAG_W_DEF    = $clog2(ROB_SIZE_DEF) + 1;
  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 64;

  // Control half of an entry; value/pc/target live in parameter-sized arrays in the top.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mispredict;
    logic       has_dest;
    logic [4:0] rd;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping head/tail pointer for the reorder buffer.
// Advances by 0..3 per cycle and can be cleared to zero.
module rob_ptr #(
  parameter int ROB_SIZE = 16,
  parameter int PTR_W    = $clog2(ROB_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [1:0]       step_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Power-of-two size, so natural overflow is the modulo wrap.
  always_comb begin
    ptr_d = ptr_q + PTR_W'(step_i);
    if (clear_i) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tagged allocation, CDB completion, in-order retire, flush on mispredict.
// Optional DUAL_COMMIT_EN adds a second retire port for head+1.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int TAG_W    = $clog2(ROB_SIZE) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  input  logic              alloc_has_dest,
  input  logic [ADDR_W-1:0] alloc_pc,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              cdb_mispredict,
  input  logic [ADDR_W-1:0] cdb_target,
  output logic              commit_valid,
  output logic              commit_wen,
  output logic [4:0]        commit_rd,
  output logic [DATA_W-1:0] commit_value,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [TAG_W-1:0]  count
`ifdef DUAL_COMMIT_EN
  ,
  output logic              commit2_valid,
  output logic              commit2_wen,
  output logic [4:0]        commit2_rd,
  output logic [DATA_W-1:0] commit2_value,
  output logic [TAG_W-1:0]  commit2_tag
`endif
);

  localparam int PTR_W = $clog2(ROB_SIZE);

  rob_entry_t        ctl_q [ROB_SIZE];
  rob_entry_t        ctl_d [ROB_SIZE];
  logic [DATA_W-1:0] value_q  [ROB_SIZE];
  logic [ADDR_W-1:0] pc_q     [ROB_SIZE];
  logic [ADDR_W-1:0] target_q [ROB_SIZE];

  logic [PTR_W-1:0]  head, tail, cdb_idx;
  logic [TAG_W-1:0]  count_q, count_d;
  logic              full, retire0, retire1, flush_now, alloc_fire, cdb_hit;
  logic [1:0]        retire_n;
  logic [ADDR_W-1:0] flush_tgt;
  logic              unused_pc;

  logic              commit_valid_q, commit_wen_q, flush_q;
  logic [4:0]        commit_rd_q;
  logic [DATA_W-1:0] commit_value_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [ADDR_W-1:0] flush_pc_q;

  assign full    = (count_q == TAG_W'(ROB_SIZE));
  assign retire0 = ctl_q[head].busy && ctl_q[head].done;

`ifdef DUAL_COMMIT_EN
  logic [PTR_W-1:0]  head1;
  logic              commit2_valid_q, commit2_wen_q;
  logic [4:0]        commit2_rd_q;
  logic [DATA_W-1:0] commit2_value_q;
  logic [TAG_W-1:0]  commit2_tag_q;

  assign head1     = head + 1'b1;
  assign retire1   = retire0 && !ctl_q[head].mispredict && ctl_q[head1].busy && ctl_q[head1].done;
  assign flush_now = (retire0 && ctl_q[head].mispredict) || (retire1 && ctl_q[head1].mispredict);
  assign flush_tgt = ctl_q[head].mispredict ? target_q[head] : target_q[head1];
`else
  assign retire1   = 1'b0;
  assign flush_now = retire0 && ctl_q[head].mispredict;
  assign flush_tgt = target_q[head];
`endif

  assign retire_n    = {1'b0, retire0} + {1'b0, retire1};
  assign alloc_ready = !full && !flush_now;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = TAG_W'(tail) + TAG_W'(1);

  assign cdb_idx = PTR_W'(cdb_tag - TAG_W'(1));
  assign cdb_hit = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SIZE)) &&
                   ctl_q[cdb_idx].busy;

  // pc is kept per entry for debug visibility; nothing downstream consumes it yet.
  assign unused_pc = ^pc_q[head];

  rob_ptr #(.ROB_SIZE(ROB_SIZE), .PTR_W(PTR_W)) u_head (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_now),
    .step_i  (retire_n),
    .ptr_o   (head)
  );

  rob_ptr #(.ROB_SIZE(ROB_SIZE), .PTR_W(PTR_W)) u_tail (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_now),
    .step_i  ({1'b0, alloc_fire}),
    .ptr_o   (tail)
  );

  always_comb begin
    ctl_d = ctl_q;
    if (cdb_hit) begin
      ctl_d[cdb_idx].done       = 1'b1;
      ctl_d[cdb_idx].mispredict = cdb_mispredict;
    end
    if (retire0) begin
      ctl_d[head].busy = 1'b0;
      ctl_d[head].done = 1'b0;
    end
`ifdef DUAL_COMMIT_EN
    if (retire1) begin
      ctl_d[head1].busy = 1'b0;
      ctl_d[head1].done = 1'b0;
    end
`endif
    if (flush_now) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ctl_d[i].busy = 1'b0;
        ctl_d[i].done = 1'b0;
      end
    end
    if (alloc_fire) begin
      ctl_d[tail].busy       = 1'b1;
      ctl_d[tail].done       = 1'b0;
      ctl_d[tail].mispredict = 1'b0;
      ctl_d[tail].has_dest   = alloc_has_dest;
      ctl_d[tail].rd         = alloc_rd;
    end
  end

  always_comb begin
    count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(retire_n);
    if (flush_now) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_SIZE; i++) ctl_q[i] <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_wen_q   <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      ctl_q          <= ctl_d;
      count_q        <= count_d;
      commit_valid_q <= retire0;
      commit_wen_q   <= retire0 && ctl_q[head].has_dest && (ctl_q[head].rd != 5'd0);
      commit_rd_q    <= retire0 ? ctl_q[head].rd : 5'd0;
      commit_value_q <= retire0 ? value_q[head] : '0;
      commit_tag_q   <= retire0 ? TAG_W'(head) + TAG_W'(1) : '0;
      flush_q        <= flush_now;
      flush_pc_q     <= flush_now ? flush_tgt : '0;
    end
  end

  // Payload needs no reset: it is only read while the matching busy/done bits are set.
  always_ff @(posedge clk) begin
    if (cdb_hit) begin
      value_q[cdb_idx]  <= cdb_value;
      target_q[cdb_idx] <= cdb_target;
    end
    if (alloc_fire) pc_q[tail] <= alloc_pc;
  end

`ifdef DUAL_COMMIT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      commit2_valid_q <= 1'b0;
      commit2_wen_q   <= 1'b0;
      commit2_rd_q    <= '0;
      commit2_value_q <= '0;
      commit2_tag_q   <= '0;
    end else begin
      commit2_valid_q <= retire1;
      commit2_wen_q   <= retire1 && ctl_q[head1].has_dest && (ctl_q[head1].rd != 5'd0);
      commit2_rd_q    <= retire1 ? ctl_q[head1].rd : 5'd0;
      commit2_value_q <= retire1 ? value_q[head1] : '0;
      commit2_tag_q   <= retire1 ? TAG_W'(head1) + TAG_W'(1) : '0;
    end
  end

  assign commit2_valid = commit2_valid_q;
  assign commit2_wen   = commit2_wen_q;
  assign commit2_rd    = commit2_rd_q;
  assign commit2_value = commit2_value_q;
  assign commit2_tag   = commit2_tag_q;
`endif

  assign commit_valid = commit_valid_q;
  assign commit_wen   = commit_wen_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: allocation, out-of-order completion, full/wrap, flush, tag-0.
// Define DUAL_COMMIT_EN on both RTL and bench to exercise the second retire port.
module tb_reorder_buffer;

  localparam int TAG_W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_has_dest;
  logic [4:0]  alloc_rd;
  logic [63:0] alloc_pc;
  logic        alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic        cdb_valid, cdb_mispredict;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0] cdb_value, cdb_target;
  logic        commit_valid, commit_wen;
  logic [4:0]  commit_rd;
  logic [63:0] commit_value;
  logic [TAG_W-1:0] commit_tag;
  logic        flush;
  logic [63:0] flush_pc;
  logic [TAG_W-1:0] count;
`ifdef DUAL_COMMIT_EN
  logic        commit2_valid, commit2_wen;
  logic [4:0]  commit2_rd;
  logic [63:0] commit2_value;
  logic [TAG_W-1:0] commit2_tag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_rd       (alloc_rd),
    .alloc_has_dest (alloc_has_dest),
    .alloc_pc       (alloc_pc),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .cdb_mispredict (cdb_mispredict),
    .cdb_target     (cdb_target),
    .commit_valid   (commit_valid),
    .commit_wen     (commit_wen),
    .commit_rd      (commit_rd),
    .commit_value   (commit_value),
    .commit_tag     (commit_tag),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .count          (count)
`ifdef DUAL_COMMIT_EN
    ,
    .commit2_valid  (commit2_valid),
    .commit2_wen    (commit2_wen),
    .commit2_rd     (commit2_rd),
    .commit2_value  (commit2_value),
    .commit2_tag    (commit2_tag)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic has_dest);
    alloc_valid    = 1'b1;
    alloc_rd       = rd;
    alloc_has_dest = has_dest;
    alloc_pc       = 64'h1000 + 64'(rd) * 4;
    step();
    alloc_valid    = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [63:0] val,
                     input logic mis, input logic [63:0] tgt);
    cdb_valid      = 1'b1;
    cdb_tag        = tag;
    cdb_value      = val;
    cdb_mispredict = mis;
    cdb_target     = tgt;
    step();
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 1'b0; alloc_rd = '0; alloc_has_dest = 1'b0; alloc_pc = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target = '0;
    step();
    step();
    reset = 1'b0;

    check("rst_count", count, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_tag", alloc_tag, 1);
    check("rst_cvalid", commit_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);

`ifndef DUAL_COMMIT_EN
    // Three allocations, then out-of-order completion retires in program order.
    for (int i = 1; i <= 3; i++) begin
      check("alloc_tag_seq", alloc_tag, 64'(i));
      alloc(5'(i), 1'b1);
    end
    check("count_3", count, 3);
    step();
    check("no_commit_before_cdb", commit_valid, 0);
    cdb(5'd2, 64'h22, 1'b0, 64'h0);
    check("no_commit_tag2_only", commit_valid, 0);
    cdb(5'd1, 64'h11, 1'b0, 64'h0);
    check("no_commit_same_cycle", commit_valid, 0);
    step();
    check("c1_valid", commit_valid, 1);
    check("c1_wen", commit_wen, 1);
    check("c1_rd", commit_rd, 1);
    check("c1_value", commit_value, 64'h11);
    check("c1_tag", commit_tag, 1);
    step();
    check("c2_valid", commit_valid, 1);
    check("c2_rd", commit_rd, 2);
    check("c2_value", commit_value, 64'h22);
    check("c2_tag", commit_tag, 2);
    step();
    check("c3_idle", commit_valid, 0);
    check("count_1", count, 1);

    // Reset mid-operation wipes the pending tag 3.
    pulse_reset();
    check("midrst_count", count, 0);
    check("midrst_tag", alloc_tag, 1);
    cdb(5'd3, 64'h33, 1'b0, 64'h0);
    step();
    check("midrst_cdb_ignored", commit_valid, 0);
    check("midrst_count_hold", count, 0);

    // Fill to capacity, then wrap.
    for (int i = 0; i < 16; i++) alloc(5'(i + 1), 1'b1);
    check("full_count", count, 16);
    check("full_ready", alloc_ready, 0);
    check("full_tag_wrap", alloc_tag, 1);
    alloc(5'd9, 1'b1);
    check("full_alloc_dropped", count, 16);
    cdb(5'd1, 64'hA1, 1'b0, 64'h0);
    check("full_ready_while_retiring", alloc_ready, 0);
    step();
    check("full_c_valid", commit_valid, 1);
    check("full_c_tag", commit_tag, 1);
    check("full_c_value", commit_value, 64'hA1);
    check("full_count_15", count, 15);
    check("full_ready_again", alloc_ready, 1);
    check("full_next_tag", alloc_tag, 1);
    alloc(5'd20, 1'b1);
    check("full_refill", count, 16);
    check("full_tag_after_refill", alloc_tag, 2);

    // Mispredicted branch at tag 2 flushes when it reaches the head.
    pulse_reset();
    for (int i = 4; i <= 7; i++) alloc(5'(i), 1'b1);
    check("mp_count4", count, 4);
    cdb(5'd2, 64'h2, 1'b1, 64'h8000);
    cdb(5'd1, 64'h1, 1'b0, 64'h0);
    check("mp_ready_before", alloc_ready, 1);
    step();
    check("mp_c1_tag", commit_tag, 1);
    check("mp_c1_flush", flush, 0);
    check("mp_ready_flush_cycle", alloc_ready, 0);
    alloc(5'd9, 1'b1);
    check("mp_c2_valid", commit_valid, 1);
    check("mp_c2_tag", commit_tag, 2);
    check("mp_c2_value", commit_value, 64'h2);
    check("mp_c2_rd", commit_rd, 5);
    check("mp_flush", flush, 1);
    check("mp_flush_pc", flush_pc, 64'h8000);
    check("mp_count0", count, 0);
    check("mp_next_tag", alloc_tag, 1);
    step();
    check("mp_flush_pulse_end", flush, 0);
    check("mp_flush_pc_clr", flush_pc, 0);
    check("mp_alloc_dropped", count, 0);
    cdb(5'd3, 64'h3, 1'b0, 64'h0);
    step();
    check("mp_freed_cdb_ignored", commit_valid, 0);

    // rd 0 and has_dest=0 never write; tag 0 is ignored.
    alloc(5'd0, 1'b1);
    cdb(5'd0, 64'h55, 1'b0, 64'h0);
    step();
    check("tag0_no_commit", commit_valid, 0);
    check("tag0_count", count, 1);
    cdb(5'd1, 64'h77, 1'b0, 64'h0);
    step();
    check("rd0_valid", commit_valid, 1);
    check("rd0_wen", commit_wen, 0);
    check("rd0_value", commit_value, 64'h77);
    alloc(5'd3, 1'b0);
    cdb(5'd2, 64'h88, 1'b0, 64'h0);
    step();
    check("nodest_valid", commit_valid, 1);
    check("nodest_wen", commit_wen, 0);
    check("nodest_tag", commit_tag, 2);
    check("nodest_count", count, 0);
`else
    // Two completed entries retire together.
    alloc(5'd1, 1'b1);
    alloc(5'd2, 1'b1);
    alloc(5'd3, 1'b1);
    cdb(5'd2, 64'h22, 1'b0, 64'h0);
    cdb(5'd1, 64'h11, 1'b0, 64'h0);
    step();
    check("dual_c1_valid", commit_valid, 1);
    check("dual_c1_tag", commit_tag, 1);
    check("dual_c1_value", commit_value, 64'h11);
    check("dual_c2_valid", commit2_valid, 1);
    check("dual_c2_tag", commit2_tag, 2);
    check("dual_c2_value", commit2_value, 64'h22);
    check("dual_c2_wen", commit2_wen, 1);
    check("dual_count", count, 1);
    step();
    check("dual_idle", commit_valid, 0);
    check("dual_idle2", commit2_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
